// File: rtl/mat_operand_feeder_pkg.sv
// Shared definitions for the matrix operand feeder: default sizes, FSM state encodings, element packing.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package mat_operand_feeder_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DIM_DEF    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Bit offset of element (r,c) in a row-major packed DIMxDIM matrix.
    function automatic int elem_off(input int r, input int c, input int dim, input int dw);
        return (r * dim + c) * dw;
    endfunction

    // clog2 that never returns zero, so counters and indices keep at least one bit.
    function automatic int min1_clog2(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/dot_idx_cnt.sv
// Nested i/j/k loop counter for C=A*B: k fastest, then j, then i, each wrapping at DIM-1.
// Latency: counts update on the edge where en_i=1; clr_i wins over en_i.
// Backpressure: en_i low freezes all three counters.
module dot_idx_cnt #(
    parameter int DIM   = 2,
    parameter int CNT_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] i_o,
    output logic [CNT_W-1:0] j_o,
    output logic [CNT_W-1:0] k_o,
    output logic             k_first_o,
    output logic             k_last_o,
    output logic             term_o
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(DIM - 1);

    logic [CNT_W-1:0] i_q, i_d;
    logic [CNT_W-1:0] j_q, j_d;
    logic [CNT_W-1:0] k_q, k_d;

    // Next count: clear to origin, or step k and ripple wraps into j and i.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        k_d = k_q;
        if (clr_i) begin
            i_d = '0;
            j_d = '0;
            k_d = '0;
        end else if (en_i) begin
            if (k_q == MAX) begin
                k_d = '0;
                if (j_q == MAX) begin
                    j_d = '0;
                    i_d = (i_q == MAX) ? '0 : i_q + 1'b1;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end else begin
                k_d = k_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            k_q <= k_d;
        end
    end

    assign i_o       = i_q;
    assign j_o       = j_q;
    assign k_o       = k_q;
    assign k_first_o = (k_q == '0);
    assign k_last_o  = (k_q == MAX);
    assign term_o    = (i_q == MAX) && (j_q == MAX) && (k_q == MAX);

endmodule

// File: rtl/mat_operand_feeder.sv
// Captures one A/B matrix pair and streams the DIM^3 operand pairs of C=A*B to the MAC cell.
// Latency: first pair registered one edge after acceptance, one pair per edge, done pulse one edge after the last pair.
// Backpressure: I_hold freezes issue (ena drops, outputs hold); O_load_ready is high only in IDLE.
module mat_operand_feeder
    import mat_operand_feeder_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DIM    = DIM_DEF,
    localparam int IDX_W  = min1_clog2(DIM * DIM),
    localparam int CNT_W  = min1_clog2(DIM),
    localparam int MAT_W  = DIM * DIM * DATA_W
) (
    input  logic              I_sys_clk,
    input  logic              I_sys_rstn,
    input  logic              I_load_valid,
    output logic              O_load_ready,
    input  logic [MAT_W-1:0]  I_mat_a,
    input  logic [MAT_W-1:0]  I_mat_b,
    input  logic              I_hold,
    output logic              O_cell_mult_ena,
    output logic [DATA_W-1:0] O_data1,
    output logic [DATA_W-1:0] O_data2,
    output logic              O_first,
    output logic              O_last,
    output logic [IDX_W-1:0]  O_elem_idx,
    output logic              O_busy,
    output logic              O_done
);

    state_e            state_q, state_d;
    logic [MAT_W-1:0]  mat_a_q, mat_b_q;
    logic              ena_q, first_q, last_q, done_q;
    logic [DATA_W-1:0] data1_q, data2_q;
    logic [IDX_W-1:0]  idx_q;

    logic              load_acc;
    logic              issue;
    logic [CNT_W-1:0]  cnt_i, cnt_j, cnt_k;
    logic              cnt_first, cnt_last, cnt_term;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic [IDX_W-1:0]  sel_idx;

    dot_idx_cnt #(
        .DIM   (DIM),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_i     (I_sys_clk),
        .rst_ni    (I_sys_rstn),
        .clr_i     (load_acc),
        .en_i      (issue),
        .i_o       (cnt_i),
        .j_o       (cnt_j),
        .k_o       (cnt_k),
        .k_first_o (cnt_first),
        .k_last_o  (cnt_last),
        .term_o    (cnt_term)
    );

    // Next-state logic and the per-edge accept / issue strobes.
    always_comb begin
        state_d  = state_q;
        load_acc = 1'b0;
        issue    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (I_load_valid) begin
                    load_acc = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!I_hold) begin
                    issue = 1'b1;
                    if (cnt_term) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand selection for the current (i,j,k): A[i][k], B[k][j], target i*DIM+j.
    always_comb begin
        sel_a   = mat_a_q[elem_off(int'(cnt_i), int'(cnt_k), DIM, DATA_W) +: DATA_W];
        sel_b   = mat_b_q[elem_off(int'(cnt_k), int'(cnt_j), DIM, DATA_W) +: DATA_W];
        sel_idx = IDX_W'(int'(cnt_i) * DIM + int'(cnt_j));
    end

    // State register.
    always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
        if (!I_sys_rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Matrix capture on acceptance; operands are not resampled until the next accept.
    always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
        if (!I_sys_rstn) begin
            mat_a_q <= '0;
            mat_b_q <= '0;
        end else if (load_acc) begin
            mat_a_q <= I_mat_a;
            mat_b_q <= I_mat_b;
        end
    end

    // Registered MAC-side outputs; pair fields hold their last issued value while not issuing.
    always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
        if (!I_sys_rstn) begin
            ena_q   <= 1'b0;
            done_q  <= 1'b0;
            data1_q <= '0;
            data2_q <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            ena_q  <= issue;
            done_q <= (state_q == ST_DONE);
            if (issue) begin
                data1_q <= sel_a;
                data2_q <= sel_b;
                first_q <= cnt_first;
                last_q  <= cnt_last;
                idx_q   <= sel_idx;
            end
        end
    end

    assign O_load_ready    = (state_q == ST_IDLE);
    assign O_busy          = (state_q != ST_IDLE);
    assign O_cell_mult_ena = ena_q;
    assign O_data1         = data1_q;
    assign O_data2         = data2_q;
    assign O_first         = first_q;
    assign O_last          = last_q;
    assign O_elem_idx      = idx_q;
    assign O_done          = done_q;

endmodule

// File: tb/tb_mat_operand_feeder.sv
// Bench for mat_operand_feeder: directed and random loads checked against a matrix-product reference.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: I_hold driven from directed patterns or randomly.
module tb_mat_operand_feeder;

    localparam int DATA_W = 8;
    localparam int DIM    = 2;
    localparam int NE     = DIM * DIM;
    localparam int N      = DIM * DIM * DIM;
    localparam int MAT_W  = NE * DATA_W;

    logic              clk        = 1'b0;
    logic              rstn       = 1'b1;
    logic              load_valid = 1'b0;
    logic              hold       = 1'b0;
    logic [MAT_W-1:0]  mat_a      = '0;
    logic [MAT_W-1:0]  mat_b      = '0;
    logic              load_ready, ena, first, last, busy, done;
    logic [DATA_W-1:0] d1, d2;
    logic [1:0]        idx;

    int checks = 0;
    int errors = 0;

    int exp_d1[N], exp_d2[N], exp_first[N], exp_last[N], exp_idx[N];
    int c_exp[NE], c_obs[NE];

    mat_operand_feeder #(.DATA_W(DATA_W), .DIM(DIM)) dut (
        .I_sys_clk       (clk),
        .I_sys_rstn      (rstn),
        .I_load_valid    (load_valid),
        .O_load_ready    (load_ready),
        .I_mat_a         (mat_a),
        .I_mat_b         (mat_b),
        .I_hold          (hold),
        .O_cell_mult_ena (ena),
        .O_data1         (d1),
        .O_data2         (d2),
        .O_first         (first),
        .O_last          (last),
        .O_elem_idx      (idx),
        .O_busy          (busy),
        .O_done          (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int elem(input logic [MAT_W-1:0] m, input int r, input int c);
        return int'(m[(r * DIM + c) * DATA_W +: DATA_W]);
    endfunction

    // Reference: dot-product terms in C-element order, plus the full product C=A*B.
    task automatic build_model(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
        int n;
        n = 0;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                c_exp[i * DIM + j] = 0;
                for (int k = 0; k < DIM; k++) begin
                    exp_d1[n]    = elem(a, i, k);
                    exp_d2[n]    = elem(b, k, j);
                    exp_first[n] = (k == 0) ? 1 : 0;
                    exp_last[n]  = (k == DIM - 1) ? 1 : 0;
                    exp_idx[n]   = i * DIM + j;
                    c_exp[i * DIM + j] += elem(a, i, k) * elem(b, k, j);
                    n++;
                end
            end
        end
    endtask

    // One complete operation starting from IDLE at a falling edge; ends just after the done edge.
    task automatic run_op(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b,
                          input logic [31:0] hold_pat, input bit rnd_hold, input bit keep_valid,
                          input logic [MAT_W-1:0] na, input logic [MAT_W-1:0] nb);
        int n;
        bit h;
        build_model(a, b);
        for (int e = 0; e < NE; e++) c_obs[e] = 0;
        chk("ready_before_load", load_ready, 1);
        load_valid = 1'b1;
        mat_a      = a;
        mat_b      = b;
        hold       = 1'b0;
        @(negedge clk);
        if (keep_valid) begin
            mat_a = na;
            mat_b = nb;
        end else begin
            load_valid = 1'b0;
            mat_a      = MAT_W'($urandom);
            mat_b      = MAT_W'($urandom);
        end
        chk("busy_after_accept", busy, 1);
        chk("ready_after_accept", load_ready, 0);
        chk("ena_after_accept", ena, 0);
        chk("done_after_accept", done, 0);
        n = 0;
        for (int c = 0; c < 200 && n < N; c++) begin
            if (rnd_hold) h = ($urandom_range(0, 2) == 0);
            else          h = (c < 32) ? hold_pat[c] : 1'b0;
            hold = h;
            @(negedge clk);
            if (!h) begin
                chk("ena", ena, 1);
                chk("data1", d1, exp_d1[n]);
                chk("data2", d2, exp_d2[n]);
                chk("first", first, exp_first[n]);
                chk("last", last, exp_last[n]);
                chk("elem_idx", idx, exp_idx[n]);
                c_obs[exp_idx[n]] += int'(d1) * int'(d2);
                n++;
            end else begin
                chk("ena_held", ena, 0);
                if (n > 0) begin
                    chk("data1_held", d1, exp_d1[n-1]);
                    chk("data2_held", d2, exp_d2[n-1]);
                    chk("idx_held", idx, exp_idx[n-1]);
                    chk("last_held", last, exp_last[n-1]);
                end
            end
            chk("done_during_issue", done, 0);
            chk("busy_during_issue", busy, 1);
        end
        chk("all_beats_issued", n, N);
        hold = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("ena_at_done", ena, 0);
        chk("ready_at_done", load_ready, 1);
        chk("busy_at_done", busy, 0);
        for (int e = 0; e < NE; e++) chk("c_elem", c_obs[e], c_exp[e]);
        hold = 1'b0;
    endtask

    logic [MAT_W-1:0] ta, tb_m, fa, fb, ra, rb;

    initial begin
        ta   = {8'd4, 8'd3, 8'd2, 8'd1};
        tb_m = {8'd8, 8'd7, 8'd6, 8'd5};
        fa   = {NE{8'hFF}};
        fb   = {NE{8'h01}};

        // Reset held for five cycles.
        #2 rstn = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_ready", load_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ena", ena, 0);
        chk("rst_done", done, 0);
        chk("rst_data1", d1, 0);
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ready", load_ready, 1);
            chk("idle_ena", ena, 0);
            chk("idle_done", done, 0);
        end

        // Reference matrices, no hold.
        run_op(ta, tb_m, 32'h0, 1'b0, 1'b0, '0, '0);
        chk("c00_const", c_obs[0], 19);
        chk("c01_const", c_obs[1], 22);
        chk("c10_const", c_obs[2], 43);
        chk("c11_const", c_obs[3], 50);
        @(negedge clk);
        chk("done_one_cycle", done, 0);

        // Hold for three edges after beat 3.
        run_op(ta, tb_m, 32'h38, 1'b0, 1'b0, '0, '0);
        @(negedge clk);

        // Valid held high through the op; second load accepted back-to-back after done.
        run_op(ta, tb_m, 32'h0, 1'b0, 1'b1, fa, fb);
        run_op(fa, fb, 32'h0, 1'b0, 1'b0, '0, '0);
        for (int e = 0; e < NE; e++) chk("c_510", c_obs[e], 510);
        @(negedge clk);

        // Reset during beat 5.
        build_model(ta, tb_m);
        load_valid = 1'b1;
        mat_a      = ta;
        mat_b      = tb_m;
        @(negedge clk);
        load_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("pre_rst_ena", ena, 1);
            chk("pre_rst_idx", idx, exp_idx[c]);
        end
        rstn = 1'b0;
        #1;
        chk("midrst_ena", ena, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", load_ready, 1);
        chk("midrst_done", done, 0);
        chk("midrst_idx", idx, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_done", done, 0);
            chk("post_rst_ena", ena, 0);
            chk("post_rst_busy", busy, 0);
        end
        run_op(ta, tb_m, 32'h0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);

        // Random matrices with random stalls.
        for (int t = 0; t < 4; t++) begin
            ra = MAT_W'({$urandom, $urandom});
            rb = MAT_W'({$urandom, $urandom});
            run_op(ra, rb, 32'h0, 1'b1, 1'b0, '0, '0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
